// File: rtl/debug_sel_pkg.sv
`default_nettype none
// ============================================================================
// Module  : debug_sel_pkg
// Purpose : Shared types and constants for the debug value selector.
//           Provides the request FSM state encoding, the register-index
//           width and the reset value of the displayed byte.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package debug_sel_pkg;

   // Width of every register index (selected index and debug-read index).
   localparam int C_IDX_W = 5;

   // Value shown on the display before the first successful read.
   localparam logic [7:0] C_HEX_RST = 8'h00;

   // Debug-read request state machine.
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } state_e;

endpackage : debug_sel_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module  : btn_debounce
// Purpose : Conditions one raw push-button. A two-flop synchronizer feeds a
//           stability counter; the accepted level flips only after the
//           synchronized level has disagreed with it for DEBOUNCE_CYCLES
//           consecutive cycles. A rising edge of the accepted level produces
//           a registered one-cycle pulse.
// Ports   : clk     - system clock
//           rst_n   - asynchronous active-low reset
//           btn_i   - raw asynchronous button level
//           pulse_o - one-cycle pulse on an accepted press
// Revision: 1.0 - initial release
// ============================================================================
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic pulse_o
);

   // Guard keeps a legal one-bit counter when DEBOUNCE_CYCLES is 1.
   localparam int C_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]         sync_q;
   logic               level_q;
   logic               level_d;
   logic [C_CNT_W-1:0] cnt_q;
   logic [C_CNT_W-1:0] cnt_d;
   logic               pulse_q;
   logic               pulse_d;

   // The counter only runs while the synchronized level disagrees with the
   // accepted one; any agreeing cycle restarts the stability window.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      pulse_d = 1'b0;
      if (sync_q[1] != level_q) begin
         if (cnt_q == C_CNT_MAX) begin
            level_d = sync_q[1];
            pulse_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= 2'b00;
         level_q <= 1'b0;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], btn_i};
         level_q <= level_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse_o = pulse_q;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/debug_value_selector.sv
`default_nettype none
// ============================================================================
// Module  : debug_value_selector
// Purpose : Lets the user step through CPU debug registers with next/prev
//           buttons, reads the selected register's low byte over a req/ack
//           debug port and holds it for a two-digit hex display. The value
//           is re-read periodically so live changes become visible.
// Ports   : clk      - system clock
//           rst_n    - asynchronous active-low reset
//           btn_next - raw button, advances the index
//           btn_prev - raw button, decrements the index
//           freeze   - raw switch, high discards read data
//           dbg_req  - debug read request (registered)
//           dbg_idx  - register index being read, stable during dbg_req
//           dbg_ack  - one-cycle read acknowledge
//           dbg_data - read data, valid with dbg_ack
//           hex      - byte to display
//           sel_idx  - currently selected index
//           timeout  - sticky abandoned-read flag, cleared by the next ack
// Revision: 1.0 - initial release
// ============================================================================
module debug_value_selector
   import debug_sel_pkg::*;
#(
   parameter int NUM_REGS        = 32,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REFRESH_CYCLES  = 2500000,
   parameter int ACK_TIMEOUT     = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               btn_next,
   input  logic               btn_prev,
   input  logic               freeze,
   output logic               dbg_req,
   output logic [C_IDX_W-1:0] dbg_idx,
   input  logic               dbg_ack,
   input  logic [7:0]         dbg_data,
   output logic [7:0]         hex,
   output logic [C_IDX_W-1:0] sel_idx,
   output logic               timeout
);

   localparam logic [C_IDX_W-1:0] C_IDX_MAX = C_IDX_W'(NUM_REGS - 1);
   localparam int C_REF_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam int C_WAIT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [C_REF_W-1:0]  C_REF_MAX  = C_REF_W'(REFRESH_CYCLES - 1);
   localparam logic [C_WAIT_W-1:0] C_WAIT_MAX = C_WAIT_W'(ACK_TIMEOUT - 1);

   logic               next_pulse;
   logic               prev_pulse;
   logic [1:0]         freeze_sync_q;

   state_e             state_q;
   state_e             state_d;
   logic [C_IDX_W-1:0] sel_idx_q;
   logic [C_IDX_W-1:0] sel_idx_d;
   logic               idx_chg;
   logic               pending_q;
   logic               pending_d;
   logic               pending_clr;
   logic [C_REF_W-1:0] ref_cnt_q;
   logic [C_REF_W-1:0] ref_cnt_d;
   logic [C_WAIT_W-1:0] wait_cnt_q;
   logic [C_WAIT_W-1:0] wait_cnt_d;
   logic [C_IDX_W-1:0] dbg_idx_q;
   logic [C_IDX_W-1:0] dbg_idx_d;
   logic               dbg_req_q;
   logic               dbg_req_d;
   logic [7:0]         hex_q;
   logic [7:0]         hex_d;
   logic               timeout_q;
   logic               timeout_d;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_deb_next (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_i   (btn_next),
      .pulse_o (next_pulse)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_deb_prev (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_i   (btn_prev),
      .pulse_o (prev_pulse)
   );

   // Index stepping. Simultaneous next and prev cancel each other out.
   always_comb begin
      sel_idx_d = sel_idx_q;
      idx_chg   = 1'b0;
      if (next_pulse && !prev_pulse) begin
         sel_idx_d = (sel_idx_q == C_IDX_MAX) ? '0 : sel_idx_q + 1'b1;
         idx_chg   = 1'b1;
      end else if (prev_pulse && !next_pulse) begin
         sel_idx_d = (sel_idx_q == '0) ? C_IDX_MAX : sel_idx_q - 1'b1;
         idx_chg   = 1'b1;
      end
   end

   // A change in the same cycle the FSM consumes pending must survive,
   // otherwise the new index would not be fetched until the next refresh.
   assign pending_d = (pending_q & ~pending_clr) | idx_chg;

   always_comb begin
      state_d     = state_q;
      ref_cnt_d   = ref_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      dbg_idx_d   = dbg_idx_q;
      dbg_req_d   = dbg_req_q;
      hex_d       = hex_q;
      timeout_d   = timeout_q;
      pending_clr = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pending_q || (ref_cnt_q == C_REF_MAX)) begin
               dbg_idx_d   = sel_idx_q;
               pending_clr = 1'b1;
               ref_cnt_d   = '0;
               wait_cnt_d  = '0;
               dbg_req_d   = 1'b1;
               state_d     = ST_REQ;
            end else begin
               ref_cnt_d = ref_cnt_q + 1'b1;
            end
         end
         ST_REQ: begin
            // Ack wins over an expiring wait in the same cycle.
            if (dbg_ack) begin
               if (!freeze_sync_q[1]) begin
                  hex_d = dbg_data;
               end
               timeout_d  = 1'b0;
               wait_cnt_d = '0;
               dbg_req_d  = 1'b0;
               state_d    = ST_IDLE;
            end else if (wait_cnt_q == C_WAIT_MAX) begin
               timeout_d  = 1'b1;
               wait_cnt_d = '0;
               dbg_req_d  = 1'b0;
               state_d    = ST_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         default: begin
            dbg_req_d = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         freeze_sync_q <= 2'b00;
         state_q       <= ST_IDLE;
         sel_idx_q     <= '0;
         pending_q     <= 1'b1;
         ref_cnt_q     <= '0;
         wait_cnt_q    <= '0;
         dbg_idx_q     <= '0;
         dbg_req_q     <= 1'b0;
         hex_q         <= C_HEX_RST;
         timeout_q     <= 1'b0;
      end else begin
         freeze_sync_q <= {freeze_sync_q[0], freeze};
         state_q       <= state_d;
         sel_idx_q     <= sel_idx_d;
         pending_q     <= pending_d;
         ref_cnt_q     <= ref_cnt_d;
         wait_cnt_q    <= wait_cnt_d;
         dbg_idx_q     <= dbg_idx_d;
         dbg_req_q     <= dbg_req_d;
         hex_q         <= hex_d;
         timeout_q     <= timeout_d;
      end
   end

   assign dbg_req = dbg_req_q;
   assign dbg_idx = dbg_idx_q;
   assign hex     = hex_q;
   assign sel_idx = sel_idx_q;
   assign timeout = timeout_q;

endmodule : debug_value_selector
`default_nettype wire

// File: tb/tb_debug_value_selector.sv
`default_nettype none
// ============================================================================
// Module  : tb_debug_value_selector
// Purpose : Self-checking bench for debug_value_selector. Stimulus queues the
//           expected read transactions and the debug-port responses; a
//           responder answers requests and a monitor pops and compares each
//           observed read against the queued expectation.
// Revision: 1.0 - initial release
// ============================================================================
module tb_debug_value_selector;

   localparam int C_TMO = 16;

   typedef struct {
      logic [4:0] idx;
      logic [7:0] hex;
      logic       to;
      int         len;
   } exp_t;

   typedef struct {
      bit         ack;
      int         delay;
      logic [7:0] data;
   } rsp_t;

   logic       clk;
   logic       rst_n;
   logic       btn_next;
   logic       btn_prev;
   logic       freeze;
   logic       dbg_req;
   logic [4:0] dbg_idx;
   logic       dbg_ack;
   logic [7:0] dbg_data;
   logic [7:0] hex;
   logic [4:0] sel_idx;
   logic       timeout;

   exp_t exp_q[$];
   rsp_t rsp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   stray_req = 0;
   logic [7:0] stray_data = 8'h00;
   bit   mon_active = 0;

   debug_value_selector #(
      .NUM_REGS        (32),
      .DEBOUNCE_CYCLES (4),
      .REFRESH_CYCLES  (64),
      .ACK_TIMEOUT     (C_TMO)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_next (btn_next),
      .btn_prev (btn_prev),
      .freeze   (freeze),
      .dbg_req  (dbg_req),
      .dbg_idx  (dbg_idx),
      .dbg_ack  (dbg_ack),
      .dbg_data (dbg_data),
      .hex      (hex),
      .sel_idx  (sel_idx),
      .timeout  (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic expect_read(input logic [4:0] idx, input bit ack, input int delay,
                              input logic [7:0] data, input logic [7:0] hx, input logic to);
      exp_t e;
      rsp_t r;
      r.ack = ack; r.delay = delay; r.data = data;
      e.idx = idx; e.hex = hx; e.to = to;
      e.len = ack ? delay + 1 : C_TMO;
      rsp_q.push_back(r);
      exp_q.push_back(e);
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || dbg_req || mon_active) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_done_in_time"}, (n < budget), 1);
   endtask

   task automatic press(input bit nxt, input bit prv);
      btn_next = nxt; btn_prev = prv;
      repeat (10) @(negedge clk);
      btn_next = 1'b0; btn_prev = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   // Debug-port responder: acks each request according to the queued response.
   initial begin : responder
      logic prev;
      bit   active;
      int   cnt;
      int   stray_done;
      rsp_t cur;
      prev = 1'b0; active = 0; cnt = 0; stray_done = 0;
      cur.ack = 1; cur.delay = 0; cur.data = 8'h00;
      dbg_ack = 1'b0; dbg_data = 8'h00;
      forever begin
         @(negedge clk);
         dbg_ack = 1'b0;
         if (dbg_req && !prev) begin
            active = 1; cnt = 0;
            if (rsp_q.size() > 0) cur = rsp_q.pop_front();
         end
         if (active && dbg_req) begin
            if (cur.ack && cnt == cur.delay) begin
               dbg_ack = 1'b1; dbg_data = cur.data; active = 0;
            end
            cnt++;
         end
         if (!dbg_req) begin
            active = 0;
            if (stray_done != stray_req) begin
               dbg_ack = 1'b1; dbg_data = stray_data; stray_done = stray_req;
            end
         end
         prev = dbg_req;
      end
   end

   // Monitor: matches every observed read against the next expectation.
   initial begin : monitor
      logic       prev;
      exp_t       cur;
      int         len;
      logic [4:0] start_idx;
      bit         moved;
      prev = 1'b0; len = 0; start_idx = '0; moved = 0;
      cur.idx = '0; cur.hex = '0; cur.to = 1'b0; cur.len = 0;
      forever begin
         @(negedge clk);
         if (dbg_req && !prev) begin
            chk("read_was_expected", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               cur = exp_q.pop_front();
               chk("read_idx", dbg_idx, cur.idx);
               mon_active = 1; len = 0; start_idx = dbg_idx; moved = 0;
            end
         end
         if (dbg_req && mon_active) begin
            len++;
            if (dbg_idx != start_idx) moved = 1;
         end
         if (!dbg_req && prev && mon_active) begin
            chk("idx_stable", moved, 0);
            chk("req_len", len, cur.len);
            chk("hex_after", hex, cur.hex);
            chk("timeout_after", timeout, cur.to);
            mon_active = 0;
         end
         prev = dbg_req;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      logic [3:0] bounce;
      int n;
      rst_n = 1'b0; btn_next = 1'b0; btn_prev = 1'b0; freeze = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_hex", hex, 8'h00);
      chk("rst_sel", sel_idx, 0);
      chk("rst_req", dbg_req, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_dbg_idx", dbg_idx, 0);

      // 1: automatic first read of index 0, ack two cycles after request
      expect_read(5'd0, 1, 2, 8'hA5, 8'hA5, 1'b0);
      rst_n = 1'b1;
      wait_done("first_read", 40);

      // 2: bouncing next button, then a stable press
      expect_read(5'd1, 1, 0, 8'h11, 8'h11, 1'b0);
      bounce = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         btn_next = bounce[i];
         @(negedge clk);
      end
      press(1, 0);
      wait_done("bounce_read", 40);
      chk("bounce_sel", sel_idx, 1);

      // 3: wrap-around both ways and simultaneous presses
      expect_read(5'd0, 1, 0, 8'h20, 8'h20, 1'b0);
      press(0, 1);
      wait_done("prev_read", 40);
      expect_read(5'd31, 1, 0, 8'h31, 8'h31, 1'b0);
      press(0, 1);
      wait_done("wrap_down_read", 40);
      chk("wrap_down_sel", sel_idx, 31);
      expect_read(5'd0, 1, 0, 8'h40, 8'h40, 1'b0);
      press(1, 0);
      wait_done("wrap_up_read", 40);
      chk("wrap_up_sel", sel_idx, 0);
      press(1, 1);
      chk("both_sel", sel_idx, 0);

      // 4: index change while a read of index 3 is outstanding
      expect_read(5'd1, 1, 0, 8'h01, 8'h01, 1'b0);
      press(1, 0);
      wait_done("to1_read", 40);
      expect_read(5'd2, 1, 0, 8'h02, 8'h02, 1'b0);
      press(1, 0);
      wait_done("to2_read", 40);
      expect_read(5'd3, 1, 14, 8'h33, 8'h33, 1'b0);
      expect_read(5'd4, 1, 0, 8'h44, 8'h44, 1'b0);
      btn_next = 1'b1;
      n = 0;
      while (!dbg_req && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("idx3_req_seen", (n < 40), 1);
      btn_next = 1'b0;
      repeat (6) @(negedge clk);
      btn_next = 1'b1;
      repeat (6) @(negedge clk);
      btn_next = 1'b0;
      wait_done("during_req_reads", 60);
      chk("during_req_sel", sel_idx, 4);
      repeat (8) @(negedge clk);

      // 5: unanswered read times out, next acked read clears the flag
      expect_read(5'd5, 0, 0, 8'h00, 8'h44, 1'b1);
      press(1, 0);
      wait_done("timeout_read", 60);
      chk("timeout_sticky", timeout, 1);
      expect_read(5'd6, 1, 0, 8'h3C, 8'h3C, 1'b0);
      press(1, 0);
      wait_done("recover_read", 40);

      // Ack outside a request must be ignored
      stray_data = 8'h77;
      stray_req++;
      repeat (3) @(negedge clk);
      chk("stray_ack_hex", hex, 8'h3C);
      chk("stray_ack_req", dbg_req, 0);

      // 6: freeze discards data, refresh after unfreeze updates it
      freeze = 1'b1;
      repeat (3) @(negedge clk);
      expect_read(5'd7, 1, 0, 8'hFF, 8'h3C, 1'b0);
      press(1, 0);
      wait_done("frozen_read", 40);
      freeze = 1'b0;
      repeat (3) @(negedge clk);
      expect_read(5'd7, 1, 1, 8'h5A, 8'h5A, 1'b0);
      wait_done("refresh_read", 100);
      chk("final_hex", hex, 8'h5A);
      chk("queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_debug_value_selector
`default_nettype wire

// File: doc/debug_value_selector.md
# debug_value_selector

Upstream feeder for the two-digit seven-segment hex display. Lets the user step through CPU debug registers with two push-buttons and fetches the selected register's low byte over a req/ack debug-read port. Holds the fetched byte on `hex[7:0]`, which drives the display's 8-bit input directly. Refreshes the shown value periodically so live register changes become visible.

## Interface
- `NUM_REGS`, 32: number of selectable registers; index wraps modulo this value (2..32).
- `DEBOUNCE_CYCLES`, 1000000: cycles a button level must stay stable before it is accepted.
- `REFRESH_CYCLES`, 2500000: idle cycles between automatic re-reads.
- `ACK_TIMEOUT`, 16: cycles in REQ without `dbg_ack` before abandoning the read.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous reset, active-low. One clock; reset is asynchronous and active-low.
- `btn_next` in 1: raw, asynchronous push-button; advances the index.
- `btn_prev` in 1: raw, asynchronous push-button; decrements the index.
- `freeze` in 1: raw, asynchronous slide switch; when high, captured data is discarded.
- `dbg_req` out 1: debug read request.
- `dbg_idx` out 5: register index being read; stable while `dbg_req` is high.
- `dbg_ack` in 1: one-cycle read acknowledge.
- `dbg_data` in 8: read data, valid in the `dbg_ack` cycle.
- `hex` out 8: byte to display.
- `sel_idx` out 5: current selected index (for LEDs).
- `timeout` out 1: sticky flag, set on an abandoned read, cleared on the next accepted ack.

## Operation
- **Input conditioning:** each raw input passes through a two-flop synchronizer. Buttons are then debounced: the accepted level changes only after the synchronized level has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. A rising edge of the accepted level makes a one-cycle pulse. `freeze` is synchronized only, with no debounce.
- **Index update:**
  - next pulse alone: `sel_idx` = (`sel_idx` + 1) mod `NUM_REGS`; `NUM_REGS-1` wraps to 0.
  - prev pulse alone: `sel_idx` = (`sel_idx` − 1) mod `NUM_REGS`; 0 wraps to `NUM_REGS-1`.
  - both in the same cycle: no change, no pending set.
  - any index change sets `pending`.
- **FSM states:**
  - IDLE: the refresh counter increments.
    - If `pending` is set or the counter reaches `REFRESH_CYCLES-1`: latch `dbg_idx` ← `sel_idx`, clear `pending`, clear the counter, go to REQ.
  - REQ: `dbg_req` = 1 and `dbg_idx` is held. A wait counter increments each cycle.
    - On `dbg_ack`: if `freeze` is low, `hex` ← `dbg_data`; clear `timeout`; go to IDLE.
    - If the wait counter reaches `ACK_TIMEOUT-1` with no ack: set `timeout`, keep `hex`, go to IDLE.
- An index change during REQ does not alter `dbg_idx`. It sets `pending`, so a new read is issued immediately after returning to IDLE.
- When `freeze` is high, reads still run and ack is still consumed, but `hex` holds its value.
- **Reset values:** `hex`=8'h00, `sel_idx`=0, `dbg_idx`=0, `dbg_req`=0, `timeout`=0, state IDLE, all counters 0. `pending`=1, so the first read of index 0 starts automatically after reset.
- Reset asserted mid-read drops `dbg_req` asynchronously. The debug port must tolerate an abandoned request.

## Timing
- `dbg_req` is registered: it rises the cycle after the IDLE→REQ decision and falls the cycle after `dbg_ack` is sampled.
- `hex` updates on the clock edge that samples `dbg_ack`, so the new value is visible the following cycle.
- Minimum ack latency: an ack in the first REQ cycle is accepted.
- An ack arriving while not in REQ is ignored.
- Button-to-`sel_idx` latency: 2 sync cycles + `DEBOUNCE_CYCLES` + 1 edge cycle. The first `dbg_req` follows 2 cycles later.
- `pending` set and cleared in the same cycle: set wins.

## Structure
- Shared package `debug_sel_pkg`:
  - FSM state enum (IDLE, REQ).
  - index width constant (5).
  - reset value for `hex`.
- Sub-module `btn_debounce`, instantiated twice. Contains the synchronizer, stability counter sized by `$clog2(DEBOUNCE_CYCLES)`, accepted level, and rising-edge pulse output.
- The top level contains the index counter, `pending`, the refresh and wait counters, and the FSM.

## Test plan
Run with `DEBOUNCE_CYCLES`=4, `REFRESH_CYCLES`=64, `ACK_TIMEOUT`=16.
1. Reset release, bench acks with `dbg_data`=8'hA5 two cycles after `dbg_req` → `dbg_idx`=0 during the request; `hex`=8'hA5; `dbg_req` low the cycle after ack.
2. `btn_next` bounces for 3 cycles, then holds high for 10 → `sel_idx` increments exactly once to 1; read issued with `dbg_idx`=1.
3. `btn_prev` pulse at `sel_idx`=0 → `sel_idx`=31; a `btn_next` pulse at 31 → 0; both pulses in the same cycle → unchanged.
4. `btn_next` accepted while in REQ for index 3 → `dbg_idx` stays 3 until ack; a second read with `dbg_idx`=4 starts immediately after.
5. No ack for 16 cycles → `dbg_req` drops, `timeout`=1, `hex` unchanged; the next acked read with 8'h3C → `timeout`=0, `hex`=8'h3C.
6. `freeze`=1, ack with 8'hFF → `hex` keeps its old value; after `freeze`=0, the next refresh read (within 64 idle cycles) updates `hex`.
